hxdp_axil_reg_master: RTL and testbench

//  AXI-Lite slave that turns host CSR accesses into the strobe-style register interface (reg_wr_*/reg_rd_*) consumed by the hXDP datapath.

---
 rtl/hxdp_pkg.sv | 6 +
 rtl/hxdp_axil_reg_master.sv | 112 +++++++++++
 tb/tb_hxdp_axil_reg_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hxdp_pkg.sv
// hxdp_pkg: shared FSM state encoding and AXI response codes for the hXDP register master.
package hxdp_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_BRESP, ST_RD, ST_RRESP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/hxdp_axil_reg_master.sv
// hxdp_axil_reg_master: AXI-Lite slave that issues one strobe-style register access at a time, with a watchdog.
module hxdp_axil_reg_master
  import hxdp_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT = 16,
  parameter logic [1:0] TIMEOUT_RESP = RESP_SLVERR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [7:0] timer;
  logic prio_rd;
  logic wr_req, rd_req, idle, grant_wr, grant_rd;
  logic wr_to, rd_to, wr_done, rd_done, tick_en;
  assign wr_req = s_axil_awvalid && s_axil_wvalid;
  assign rd_req = s_axil_arvalid;
  // readies are combinational so the access starts the cycle after the handshake; held low in reset
  assign idle = reset && state == ST_IDLE;
  assign grant_wr = idle && wr_req && (!rd_req || !prio_rd);
  assign grant_rd = idle && rd_req && !grant_wr;
  assign s_axil_awready = grant_wr;
  assign s_axil_wready = grant_wr;
  assign s_axil_arready = grant_rd;
  assign reg_wr_en = state == ST_WR;
  assign reg_rd_en = state == ST_RD;
  assign s_axil_bvalid = state == ST_BRESP;
  assign s_axil_rvalid = state == ST_RRESP;
  // a late ack in the expiry cycle wins over the timeout
  assign wr_to = !reg_wr_ack && !reg_wr_wait && timer == T_LAST;
  assign rd_to = !reg_rd_ack && !reg_rd_wait && timer == T_LAST;
  assign wr_done = reg_wr_en && (reg_wr_ack || wr_to);
  assign rd_done = reg_rd_en && (reg_rd_ack || rd_to);
  assign tick_en = (reg_wr_en && !reg_wr_wait && !reg_wr_ack) || (reg_rd_en && !reg_rd_wait && !reg_rd_ack);
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = grant_wr ? ST_WR : grant_rd ? ST_RD : ST_IDLE;
      ST_WR:    state_nx = wr_done ? ST_BRESP : ST_WR;
      ST_BRESP: state_nx = s_axil_bready ? ST_IDLE : ST_BRESP;
      ST_RD:    state_nx = rd_done ? ST_RRESP : ST_RD;
      ST_RRESP: state_nx = s_axil_rready ? ST_IDLE : ST_RRESP;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      timer <= '0;
      prio_rd <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      reg_rd_addr <= '0;
      s_axil_bresp <= RESP_OKAY;
      s_axil_rresp <= RESP_OKAY;
      s_axil_rdata <= '0;
    end else begin
      state <= state_nx;
      if (tick_en) timer <= timer + 8'd1;
      if (grant_wr) begin
        reg_wr_addr <= s_axil_awaddr;
        reg_wr_data <= s_axil_wdata;
        reg_wr_strb <= s_axil_wstrb;
        timer <= '0;
        if (rd_req) prio_rd <= 1'b1;
      end
      if (grant_rd) begin
        reg_rd_addr <= s_axil_araddr;
        timer <= '0;
        if (wr_req) prio_rd <= 1'b0;
      end
      if (wr_done) s_axil_bresp <= reg_wr_ack ? RESP_OKAY : TIMEOUT_RESP;
      if (rd_done) begin
        s_axil_rresp <= reg_rd_ack ? RESP_OKAY : TIMEOUT_RESP;
        s_axil_rdata <= reg_rd_ack ? reg_rd_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_hxdp_axil_reg_master.sv
// tb_hxdp_axil_reg_master: directed checks of write/read paths, ordering, timeout, arbitration and reset.
module tb_hxdp_axil_reg_master;
  logic clk = 0, reset = 0;
  logic [15:0] awaddr = 0, araddr = 0, reg_wr_addr, reg_rd_addr;
  logic [31:0] wdata = 0, rdata, reg_wr_data, reg_rd_data = 0;
  logic [3:0] wstrb = 0, reg_wr_strb;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0] bresp, rresp;
  logic reg_wr_en, reg_wr_wait = 0, reg_wr_ack = 0;
  logic reg_rd_en, reg_rd_wait = 0, reg_rd_ack = 0;
  int checks = 0, errors = 0;
  int wr_cyc = 0, rd_cyc = 0;
  int base;
  bit seen;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reg_wr_en) wr_cyc++;
    if (reg_rd_en) rd_cyc++;
  end

  hxdp_axil_reg_master dut (
    .clk(clk), .reset(reset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bready = 1;
    rready = 1;
    repeat (2) tick();
    #1;
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_bvalid", {31'd0, bvalid}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 0);
    chk("rst_rd_en", {31'd0, reg_rd_en}, 0);
    chk("rst_rdata", rdata, 0);
    tick();
    reset = 1;
    tick();

    // 1: basic write, target acks in the first en cycle
    base = wr_cyc;
    awaddr = 16'h0010; wdata = 32'hCAFEBABE; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    #1;
    chk("t1_awready", {31'd0, awready}, 1);
    chk("t1_wready", {31'd0, wready}, 1);
    tick();
    awvalid = 0; wvalid = 0; reg_wr_ack = 1;
    #1;
    chk("t1_en", {31'd0, reg_wr_en}, 1);
    chk("t1_addr", {16'd0, reg_wr_addr}, 32'h0010);
    chk("t1_data", reg_wr_data, 32'hCAFEBABE);
    chk("t1_strb", {28'd0, reg_wr_strb}, 32'hF);
    tick();
    reg_wr_ack = 0;
    #1;
    chk("t1_en_drop", {31'd0, reg_wr_en}, 0);
    chk("t1_bvalid", {31'd0, bvalid}, 1);
    chk("t1_bresp", {30'd0, bresp}, 0);
    chk("t1_en_cycles", wr_cyc - base, 1);
    tick();
    chk("t1_bdone", {31'd0, bvalid}, 0);

    // 2: W two cycles ahead of AW
    base = wr_cyc;
    wdata = 32'h11223344; wstrb = 4'h3; wvalid = 1;
    #1;
    chk("t2_wready_a", {31'd0, wready}, 0);
    tick();
    chk("t2_wready_b", {31'd0, wready}, 0);
    tick();
    awaddr = 16'h0020; awvalid = 1;
    #1;
    chk("t2_wready", {31'd0, wready}, 1);
    chk("t2_awready", {31'd0, awready}, 1);
    tick();
    awvalid = 0; wvalid = 0; reg_wr_wait = 1;
    #1;
    chk("t2_addr", {16'd0, reg_wr_addr}, 32'h0020);
    chk("t2_strb", {28'd0, reg_wr_strb}, 32'h3);
    tick();
    reg_wr_wait = 0; reg_wr_ack = 1;
    tick();
    reg_wr_ack = 0;
    #1;
    chk("t2_bvalid", {31'd0, bvalid}, 1);
    chk("t2_bresp", {30'd0, bresp}, 0);
    chk("t2_en_cycles", wr_cyc - base, 2);
    tick();

    // 3: long wait stall does not trip the watchdog
    rready = 0;
    araddr = 16'h0024; arvalid = 1;
    #1;
    chk("t3_arready", {31'd0, arready}, 1);
    tick();
    arvalid = 0; reg_rd_wait = 1;
    #1;
    chk("t3_rd_addr", {16'd0, reg_rd_addr}, 32'h0024);
    repeat (40) tick();
    chk("t3_en_held", {31'd0, reg_rd_en}, 1);
    reg_rd_wait = 0; reg_rd_ack = 1; reg_rd_data = 32'h12345678;
    tick();
    reg_rd_ack = 0; reg_rd_data = 32'hDEADDEAD;
    #1;
    chk("t3_en_drop", {31'd0, reg_rd_en}, 0);
    chk("t3_rvalid", {31'd0, rvalid}, 1);
    chk("t3_rresp", {30'd0, rresp}, 0);
    chk("t3_rdata", rdata, 32'h12345678);
    repeat (2) tick();
    chk("t3_rvalid_hold", {31'd0, rvalid}, 1);
    chk("t3_rdata_hold", rdata, 32'h12345678);
    rready = 1;
    tick();
    chk("t3_rdone", {31'd0, rvalid}, 0);

    // 4: target never acks
    base = rd_cyc;
    araddr = 16'h0030; arvalid = 1;
    tick();
    arvalid = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = rvalid;
    end
    chk("t4_seen", {31'd0, seen}, 1);
    chk("t4_en_cycles", rd_cyc - base, 16);
    chk("t4_rresp", {30'd0, rresp}, 32'h2);
    chk("t4_rdata", rdata, 0);
    tick();

    // 5: arbitration between simultaneous write and read
    awaddr = 16'h0040; wdata = 32'h0000AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 16'h0044; arvalid = 1;
    #1;
    chk("t5a_awready", {31'd0, awready}, 1);
    chk("t5a_arready", {31'd0, arready}, 0);
    tick();
    awvalid = 0; wvalid = 0; reg_wr_ack = 1;
    tick();
    reg_wr_ack = 0;
    tick();
    chk("t5a_arready_next", {31'd0, arready}, 1);
    tick();
    arvalid = 0; reg_rd_ack = 1; reg_rd_data = 32'h0000A5A5;
    tick();
    reg_rd_ack = 0;
    #1;
    chk("t5a_rdata", rdata, 32'h0000A5A5);
    tick();
    awvalid = 1; wvalid = 1; arvalid = 1;
    #1;
    chk("t5b_arready", {31'd0, arready}, 1);
    chk("t5b_awready", {31'd0, awready}, 0);
    tick();
    arvalid = 0; reg_rd_ack = 1; reg_rd_data = 32'h00005A5A;
    tick();
    reg_rd_ack = 0;
    tick();
    chk("t5b_awready_next", {31'd0, awready}, 1);
    tick();
    awvalid = 0; wvalid = 0; reg_wr_ack = 1;
    tick();
    reg_wr_ack = 0;
    tick();

    // 6: reset in the middle of a write
    bready = 0;
    awaddr = 16'h0050; wdata = 32'h55555555; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    #1;
    chk("t6_en_before", {31'd0, reg_wr_en}, 1);
    reset = 0;
    #1;
    chk("t6_en_rst", {31'd0, reg_wr_en}, 0);
    chk("t6_bvalid_rst", {31'd0, bvalid}, 0);
    chk("t6_addr_rst", {16'd0, reg_wr_addr}, 0);
    tick();
    reset = 1;
    bready = 1;
    tick();
    awaddr = 16'h0060; wdata = 32'h0BADF00D; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; reg_wr_ack = 1;
    #1;
    chk("t6_addr", {16'd0, reg_wr_addr}, 32'h0060);
    chk("t6_data", reg_wr_data, 32'h0BADF00D);
    tick();
    reg_wr_ack = 0;
    #1;
    chk("t6_bvalid", {31'd0, bvalid}, 1);
    chk("t6_bresp", {30'd0, bresp}, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
